fetch_pc_unit: RTL
==================

# fetch_pc_unit

Instruction-fetch front end that generates the next-PC value for the 32-bit PC register and consumes that register's output to issue instruction-memory requests. It tracks outstanding requests, buffers returned instruction words with their PCs in a small FIFO, and hands them to decode over a valid/ready handshake. It also accepts branch/jump redirects, which flush all in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value driven on `pc_d` while in reset.
- `DEPTH`, 2, fetch-buffer entries and maximum outstanding requests (power of two, 2..8).
- `clk` in 1, rising-edge clock.
- `rst` in 1, reset, synchronous, active-low.
- `pc_q` in 32, current PC from the PC register.
- `pc_d` out 32, next PC to the PC register, which loads it every cycle.
- `imem_req_valid` out 1, fetch request valid.
- `imem_req_addr` out 32, fetch address.
- `imem_req_ready` in 1, memory accepts the request.
- `imem_rsp_valid` in 1, instruction word returned; in order, at least 1 cycle after acceptance.
- `imem_rsp_data` in 32, instruction word.
- `redirect_valid` in 1, taken branch/jump/trap from execute.
- `redirect_pc` in 32, redirect target.
- `if_valid` out 1, instruction available to decode.
- `if_ready` in 1, decode accepts.
- `if_instr` out 32, instruction word.
- `if_pc` out 32, PC of `if_instr`.

## Operation
- Reset (`rst`=0 at a rising edge):
  - `pc_d`=RESET_PC while `rst`=0.
  - Buffer, outstanding count and drop count are cleared.
  - Outputs: `imem_req_valid`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - Reset mid-operation discards all buffered and in-flight state. Responses arriving after reset are ignored until the drop count clears (drop count is loaded with the outstanding count at reset).
- Credit rule:
  - `imem_req_valid`=1 when `rst`=1, `redirect_valid`=0, and `outstanding + buf_count < DEPTH`.
  - `imem_req_addr`=`pc_q`, with bits [1:0] forced to 0.
- Next PC, in priority order:
  - reset → RESET_PC
  - `redirect_valid` → `{redirect_pc[31:2],2'b00}`
  - request accepted (`imem_req_valid & imem_req_ready`) → `pc_q+4`, wrapping modulo 2^32 (32'hFFFF_FFFC → 0)
  - otherwise → `pc_q` (hold).
- Outstanding tracking:
  - Each accepted request pushes its address into a DEPTH-entry PC FIFO and increments `outstanding`.
  - Each response decrements `outstanding`.
  - A response is paired with the head PC and written into the instruction buffer.
- Redirect (single cycle):
  - Flushes the instruction buffer and PC FIFO.
  - Sets `drop_count = outstanding`, net of any response arriving in the same cycle.
  - Responses arriving while `drop_count>0` decrement it and are discarded.
  - `if_valid` is forced to 0 in the redirect cycle, so no decode handshake completes.
- Output: `if_valid` = buffer non-empty (or bypass, see Configuration). Pop on `if_valid & if_ready`.
- Buffer full with a response arriving is impossible by the credit rule; assert in simulation.
- Simultaneous push and pop on a full buffer is legal; the count is unchanged.

## Timing
- Request issue is combinational from `pc_q` and the counters; `pc_q` advances one cycle after acceptance.
- Back-to-back acceptance sustains one request per cycle when `imem_req_ready`=1 and decode drains.
- Response to `if_valid`:
  - 1 cycle through the buffer (response registered, then presented).
  - 0 cycles with bypass.
- Redirect to first request at the new target: the next cycle (`pc_q` = target).
- Outputs are held stable while `if_valid=1 & if_ready=0`.

## Configuration
- `FETCH_BYPASS_EN` defined: when the buffer is empty and a non-dropped response arrives, it drives `if_valid/if_instr/if_pc` combinationally in the same cycle. If `if_ready`=1, it is consumed without being written to the buffer.
- Not defined: every response is written to the buffer first (1-cycle latency). Throughput is unchanged.

## Structure
- `fetch_pkg`:
  - `RESET_PC_DEFAULT`
  - `INSTR_NOP` (32'h0000_0013)
  - `typedef struct {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t`
- Sub-module `fetch_fifo`: parameterised DEPTH, synchronous active-low `rst`, push/pop/full/empty/count. Instantiated twice: once for the PC FIFO and once for the instruction buffer.

## Test plan
- Reset held 3 cycles, then released → `pc_d`=0 during reset. First request at addr 0, then 4, 8, with one accepted per cycle while `imem_req_ready`=1.
- Responses 32'h00A00093, 32'h00100113 returned 1 cycle after their requests, `if_ready`=1 → decode sees (pc 0, 00A00093) then (pc 4, 00100113), in order with no gaps.
- `if_ready`=0 for 5 cycles → at most DEPTH requests issued. `imem_req_valid` drops to 0, outputs stay stable, no instruction is lost.
- Redirect to 32'h0000_0100 with 2 requests outstanding → both late responses are dropped. Next request is at 0x100. First `if_pc`=0x100.
- `redirect_pc`=32'h0000_0102 → the request is issued at 0x100. Separately, `pc_q`=32'hFFFF_FFFC accepted → `pc_d`=0.
- With `FETCH_BYPASS_EN`, empty buffer, response with `if_ready`=1 → `if_valid` is asserted in the same cycle and the buffer count stays 0. Without the macro → `if_valid` asserts 1 cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, the buffered fetch entry type and a word-align helper.
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry (power of two) synchronous FIFO with single-cycle flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    pop_data = mem_q[rd_q];
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: next-PC generation, imem request issue, in-flight tracking and decode buffering.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = $bits(fetch_entry_t);
  logic [AW:0] pc_cnt, buf_cnt;
  logic pc_full, pc_empty, buf_full, buf_empty;
  logic req_fire, rsp_live, buf_push, buf_pop;
  logic [31:0] head_pc;
  fetch_entry_t rsp_entry, buf_entry, out_entry;
  logic [7:0] drop_q, drop_d, drop_flush, inflight;
  always_comb begin
    imem_req_valid = rst && !redirect_valid && (({1'b0, pc_cnt} + {1'b0, buf_cnt}) < (AW+2)'(DEPTH));
    imem_req_addr = word_align(pc_q);
    req_fire = imem_req_valid && imem_req_ready;
    pc_d = !rst ? RESET_PC : redirect_valid ? word_align(redirect_pc) : req_fire ? pc_q + 32'd4 : pc_q;
    rsp_live = rst && !redirect_valid && imem_rsp_valid && drop_q == '0;
    // Everything still owed by memory becomes drop credit; a response landing now already paid one.
    inflight = drop_q + 8'(pc_cnt);
    drop_flush = inflight - 8'(imem_rsp_valid && inflight != '0);
    drop_d = redirect_valid ? drop_flush : drop_q - 8'(imem_rsp_valid && drop_q != '0);
    rsp_entry = {head_pc, imem_rsp_data};
`ifdef FETCH_BYPASS_EN
    if_valid = rst && !redirect_valid && (!buf_empty || rsp_live);
    out_entry = buf_empty ? rsp_entry : buf_entry;
    buf_push = rsp_live && !(buf_empty && if_ready);
    buf_pop = if_valid && if_ready && !buf_empty;
`else
    if_valid = rst && !redirect_valid && !buf_empty;
    out_entry = buf_entry;
    buf_push = rsp_live;
    buf_pop = if_valid && if_ready;
`endif
    if_pc = if_valid ? out_entry.pc : '0;
    if_instr = if_valid ? out_entry.instr : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) drop_q <= drop_flush;
    else drop_q <= drop_d;
  end
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_fifo (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(req_fire), .push_data(imem_req_addr),
    .pop(rsp_live), .pop_data(head_pc),
    .full(pc_full), .empty(pc_empty), .count(pc_cnt)
  );
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_buf (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(buf_push), .push_data(rsp_entry),
    .pop(buf_pop), .pop_data(buf_entry),
    .full(buf_full), .empty(buf_empty), .count(buf_cnt)
  );
  assert property (@(posedge clk) disable iff (!rst) !(rsp_live && (buf_full || pc_empty)));
  assert property (@(posedge clk) disable iff (!rst) !(req_fire && pc_full));
endmodule
